// File: rtl/conv_output_requant.sv
// Requantizes signed convolution results (optional ReLU, rounding shift, saturation)
// and replays them through a small FIFO on a valid/ready stream with frame tracking.
module conv_output_requant #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int FIFO_DEPTH         = 8,
    parameter int SHIFT_WIDTH        = 5
) (
    input  logic                                  clk,
    input  logic                                  arst_in,
    input  logic                                  start,
    input  logic [SHIFT_WIDTH-1:0]                shift_amount,
    input  logic                                  relu_en,
    input  logic [ACCUMULATION_WIDTH-1:0]         in_data,
    input  logic                                  in_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch,
    output logic [IO_DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  out_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] out_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] out_ch,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow,
    output logic                                  sat_flag,
    output logic                                  done,
    output logic                                  busy
);
    localparam int AW      = ACCUMULATION_WIDTH;
    localparam int IW      = IO_DATA_WIDTH;
    localparam int XW      = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW      = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW      = $clog2(OUTPUT_NB_CHANNELS);
    localparam int TOTAL   = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = IW + XW + YW + CW;

    localparam logic signed [AW:0]      SAT_MAX   = {{(AW + 2 - IW){1'b0}}, {(IW - 1){1'b1}}};
    localparam logic signed [AW:0]      SAT_MIN   = {{(AW + 2 - IW){1'b1}}, {(IW - 1){1'b0}}};
    localparam logic signed [AW:0]      RND_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]        LAST_C    = CNT_W'(TOTAL - 1);
    localparam logic [PTR_W:0]          DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [SHIFT_WIDTH-1:0]  shift_r;
    logic                    relu_r;
    logic                    stage_valid_r;
    logic [ENTRY_W-1:0]      stage_entry_r;
    logic                    sat_flag_r;
    logic [ENTRY_W-1:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W:0]          count_r;
    logic                    overflow_r;
    logic [CNT_W-1:0]        pop_cnt_r;
    state_t                  state_r;
    logic                    busy_r;
    logic                    done_r;

    logic [AW-1:0]           relu_s;
    logic signed [AW:0]      ext_s;
    logic signed [AW:0]      rnd_s;
    logic signed [AW:0]      shifted_s;
    logic [IW-1:0]           quant_s;
    logic                    clamp_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    accept_s;
    logic [ENTRY_W-1:0]      head_s;

    // ReLU, round-half-up arithmetic shift and clamp of the incoming result
    always_comb begin
        relu_s    = in_data;
        ext_s     = '0;
        rnd_s     = '0;
        shifted_s = '0;
        quant_s   = '0;
        clamp_s   = 1'b0;
        if (relu_r && in_data[AW-1]) begin
            relu_s = '0;
        end else begin
            relu_s = in_data;
        end
        ext_s = {relu_s[AW-1], relu_s};
        if (shift_r != '0) begin
            rnd_s = ext_s + (RND_ONE << (shift_r - SHIFT_WIDTH'(1)));
        end else begin
            rnd_s = ext_s;
        end
        shifted_s = rnd_s >>> shift_r;
        if (shifted_s > SAT_MAX) begin
            quant_s = SAT_MAX[IW-1:0];
            clamp_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            quant_s = SAT_MIN[IW-1:0];
            clamp_s = 1'b1;
        end else begin
            quant_s = shifted_s[IW-1:0];
            clamp_s = 1'b0;
        end
    end

    // Configuration is captured only on start
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            shift_r <= '0;
            relu_r  <= 1'b0;
        end else if (start) begin
            shift_r <= shift_amount;
            relu_r  <= relu_en;
        end else begin
            shift_r <= shift_r;
            relu_r  <= relu_r;
        end
    end

    // Stage register and sticky saturation flag; a result arriving with start is discarded
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            stage_valid_r <= 1'b0;
            stage_entry_r <= '0;
            sat_flag_r    <= 1'b0;
        end else if (start) begin
            stage_valid_r <= 1'b0;
            stage_entry_r <= stage_entry_r;
            sat_flag_r    <= 1'b0;
        end else begin
            stage_valid_r <= in_valid;
            if (in_valid) begin
                stage_entry_r <= {quant_s, in_x, in_y, in_ch};
                sat_flag_r    <= sat_flag_r | clamp_s;
            end else begin
                stage_entry_r <= stage_entry_r;
                sat_flag_r    <= sat_flag_r;
            end
        end
    end

    always_comb begin
        push_s   = stage_valid_r;
        pop_s    = (count_r != '0) && out_ready;
        full_s   = (count_r == DEPTH_C);
        // a full FIFO still accepts when the head leaves in the same cycle
        accept_s = push_s && (!full_s || pop_s);
        head_s   = mem_r[rd_ptr_r];
    end

    // FIFO storage, pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (start) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= stage_entry_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Frame control: saturating pop counter with IDLE/RUN/DONE sequencing
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pop_cnt_r <= '0;
        end else if (start) begin
            state_r   <= RUN;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            pop_cnt_r <= '0;
        end else begin
            if (pop_s && (pop_cnt_r != TOTAL_C)) begin
                pop_cnt_r <= pop_cnt_r + CNT_W'(1);
            end else begin
                pop_cnt_r <= pop_cnt_r;
            end
            case (state_r)
                RUN: begin
                    if (pop_s && (pop_cnt_r == LAST_C)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = (count_r != '0);
    assign {out_data, out_x, out_y, out_ch} = head_s;
    assign overflow  = overflow_r;
    assign sat_flag  = sat_flag_r;
    assign done      = done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_conv_output_requant.sv
// Scoreboard bench for conv_output_requant: directed vectors push expected entries,
// an independent monitor pops and compares whenever the DUT hands off a result.
module tb_conv_output_requant;
    localparam int AW = 32;
    localparam int IW = 16;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          arst_in = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] shift_amount = '0;
    logic          relu_en = 1'b0;
    logic [AW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_x = 1'b0;
    logic          in_y = 1'b0;
    logic          in_ch = 1'b0;
    logic [IW-1:0] out_data;
    logic          out_x;
    logic          out_y;
    logic          out_ch;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overflow;
    logic          sat_flag;
    logic          done;
    logic          busy;

    int            n_pass = 0;
    int            n_checks = 0;
    int            cyc = 0;
    int            pop_total = 0;
    int            last_pop_cyc = 0;
    int            base;
    logic [31:0]   exp_q[$];

    conv_output_requant #(
        .ACCUMULATION_WIDTH(AW),
        .IO_DATA_WIDTH(IW),
        .FEATURE_MAP_WIDTH(2),
        .FEATURE_MAP_HEIGHT(2),
        .OUTPUT_NB_CHANNELS(2),
        .FIFO_DEPTH(8),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .arst_in(arst_in),
        .start(start),
        .shift_amount(shift_amount),
        .relu_en(relu_en),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_x(in_x),
        .in_y(in_y),
        .in_ch(in_ch),
        .out_data(out_data),
        .out_x(out_x),
        .out_y(out_y),
        .out_ch(out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow),
        .sat_flag(sat_flag),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack(input logic [15:0] d, input logic x, input logic y, input logic ch);
        return {13'd0, d, x, y, ch};
    endfunction

    // Monitor: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!arst_in && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", pack(out_data, out_x, out_y, out_ch), 32'hFFFF_FFFF);
            end else begin
                check("out_entry", pack(out_data, out_x, out_y, out_ch), exp_q.pop_front());
            end
            pop_total++;
            last_pop_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // start pulse with a junk result that must be discarded; config lines then wiggle
    task automatic do_start(input logic [SW-1:0] sh, input logic relu);
        shift_amount = sh;
        relu_en      = relu;
        start        = 1'b1;
        in_valid     = 1'b1;
        in_data      = 32'h0005_5555;
        tick();
        start        = 1'b0;
        in_valid     = 1'b0;
        shift_amount = ~sh;
        relu_en      = ~relu;
    endtask

    task automatic send(input logic [31:0] d, input int idx, input logic [15:0] e, input bit expect_out);
        in_data  = d;
        in_x     = idx[0];
        in_y     = idx[1];
        in_ch    = idx[2];
        in_valid = 1'b1;
        if (expect_out) exp_q.push_back(pack(e, idx[0], idx[1], idx[2]));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {30'd0, overflow, sat_flag}, 32'd0);
        check("rst_out_data", pack(out_data, out_x, out_y, out_ch), 32'd0);
        tick();
        arst_in = 1'b0;
        tick();

        // rounding, latency N+2, coordinates
        out_ready = 1'b1;
        do_start(5'd8, 1'b0);
        check("start_busy", {31'd0, busy}, 32'd1);
        send(32'h0001_2345, 5, 16'h0123, 1'b1);
        check("lat_n1", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_n2", {31'd0, out_valid}, 32'd1);
        ticks(3);

        // negative rounding, then ReLU
        do_start(5'd2, 1'b0);
        send(32'hFFFF_FED4, 2, 16'hFFB5, 1'b1);
        ticks(3);
        do_start(5'd2, 1'b1);
        send(32'hFFFF_FED4, 3, 16'h0000, 1'b1);
        send(32'd7, 6, 16'h0002, 1'b1);
        ticks(4);

        // saturation and sticky sat_flag
        do_start(5'd0, 1'b0);
        check("sat_clear0", {31'd0, sat_flag}, 32'd0);
        send(32'h7FFF_FFFF, 1, 16'h7FFF, 1'b1);
        check("sat_set", {31'd0, sat_flag}, 32'd1);
        send(32'h8000_0000, 4, 16'h8000, 1'b1);
        send(32'd5, 7, 16'h0005, 1'b1);
        ticks(4);
        check("sat_sticky", {31'd0, sat_flag}, 32'd1);
        do_start(5'd0, 1'b0);
        check("sat_cleared", {31'd0, sat_flag}, 32'd0);

        // overflow: nine pushes into an eight-entry FIFO with no drain
        out_ready = 1'b0;
        do_start(5'd0, 1'b0);
        for (int i = 1; i <= 9; i++) send(i, i, 16'(i), i <= 8);
        ticks(3);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_head", {16'd0, out_data}, 32'd1);
        out_ready = 1'b1;
        ticks(10);
        check("ovf_drained", {31'd0, out_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_done_after_8", {31'd0, done}, 32'd1);

        // done/counter with random backpressure
        do_start(5'd0, 1'b0);
        check("frame_done_clr", {31'd0, done}, 32'd0);
        check("frame_busy", {31'd0, busy}, 32'd1);
        check("frame_ovf_clr", {31'd0, overflow}, 32'd0);
        base = pop_total;
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(32'(10 + i), i, 16'(10 + i), 1'b1);
        end
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("done_rise", {31'd0, done}, 32'd1);
        check("done_timing", 32'(cyc - last_pop_cyc), 32'd1);
        check("done_pops", 32'(pop_total - base), 32'd8);
        check("done_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        send(32'd99, 7, 16'd99, 1'b1);
        ticks(4);
        check("post_done", {31'd0, done}, 32'd1);
        check("post_done_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-frame with three entries held
        out_ready = 1'b0;
        do_start(5'd0, 1'b0);
        send(32'h7FFF_FFFF, 1, 16'd0, 1'b0);
        send(32'd3, 2, 16'd0, 1'b0);
        send(32'd4, 3, 16'd0, 1'b0);
        ticks(3);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        arst_in = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_flags", {30'd0, overflow, sat_flag}, 32'd0);
        check("arst_data", {16'd0, out_data}, 32'd0);
        tick();
        arst_in = 1'b0;
        tick();
        out_ready = 1'b1;
        do_start(5'd8, 1'b0);
        send(32'h0001_2345, 6, 16'h0123, 1'b1);
        check("rst_lat_n1", {31'd0, out_valid}, 32'd0);
        tick();
        check("rst_lat_n2", {31'd0, out_valid}, 32'd1);
        ticks(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_output_requant.md
Name: conv_output_requant

Overview:
- Downstream consumer of the top_system convolution output stream.
- Takes ACCUMULATION_WIDTH results tagged with x/y/ch and applies optional ReLU, a rounding arithmetic right shift, and saturation to IO_DATA_WIDTH.
- Buffers results in a small FIFO and re-emits them on a valid/ready stream.
- The upstream has no backpressure, so the block counts completed outputs and flags any dropped data.

Parameters:
- ACCUMULATION_WIDTH, 32, input result width (signed)
- IO_DATA_WIDTH, 16, output data width (signed)
- FEATURE_MAP_WIDTH, 128, x range
- FEATURE_MAP_HEIGHT, 128, y range
- OUTPUT_NB_CHANNELS, 16, ch range
- FIFO_DEPTH, 8, buffer entries (power of 2, >=2)
- SHIFT_WIDTH, 5, width of shift_amount

Ports:
- clk  in  1  clock, all state updates on rising edge
- arst_in  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; clears state and samples config
- shift_amount  in  SHIFT_WIDTH  right-shift count, sampled at start
- relu_en  in  1  ReLU enable, sampled at start
- in_data  in  ACCUMULATION_WIDTH  signed result (top_system out)
- in_valid  in  1  result valid (top_system output_valid); no ready exists
- in_x / in_y / in_ch  in  $clog2(FEATURE_MAP_WIDTH) / $clog2(FEATURE_MAP_HEIGHT) / $clog2(OUTPUT_NB_CHANNELS)  result coordinates
- out_data  out  IO_DATA_WIDTH  requantized value
- out_x / out_y / out_ch  out  same widths as inputs  coordinates travelling with out_data
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accept
- overflow  out  1  sticky; a result was dropped because the FIFO was full
- sat_flag  out  1  sticky; at least one result saturated
- done  out  1  all W*H*C outputs handed off
- busy  out  1  started and not done

Behaviour:
- Reset (arst_in=1, async, any time including mid-frame):
  - FIFO emptied, stage register invalid, counter 0.
  - shift reg 0, relu reg 0.
  - All outputs 0: out_valid, overflow, sat_flag, done, busy, out_data, out_x, out_y, out_ch.
- Config: shift_amount and relu_en are latched only on start; changes at other times are ignored.
- Stage 1 (registered), when in_valid:
  - v = relu_en && in_data<0 ? 0 : in_data.
  - Extend v to ACCUMULATION_WIDTH+1 bits.
  - If shift>0, add 1<<(shift-1) (round half up); then arithmetic shift right by shift.
  - Saturate to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1]; set sat_flag on clamp.
  - Capture x/y/ch alongside the data.
- Stage 2: a valid stage register is written into the FIFO on the next edge.
- Latency: in_valid in cycle N -> out_valid high in cycle N+2 (FIFO empty, no stall).
- Output: out_valid = !empty. out_data, out_x, out_y and out_ch show the FIFO head and hold while out_valid && !out_ready. Pop occurs when out_valid && out_ready.
- Full:
  - Push and pop in the same cycle while full is allowed; occupancy is unchanged and nothing is dropped.
  - Push while full without pop: entry dropped, overflow set (sticky until start/reset), FIFO contents unchanged.
- Counter: increments per pop and saturates at TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS; width $clog2(TOTAL+1).
  - done rises the cycle after the pop that reaches TOTAL and holds until start/reset.
- busy: set the cycle after start, cleared together with done rising.
- start:
  - Synchronously clears FIFO, stage register, counter, overflow, sat_flag and done; sets busy.
  - An in_valid in the same cycle as start is discarded.
- Post-done inputs: still processed and emitted; counter stays at TOTAL.
- States: IDLE (busy=0, done=0) -> start -> RUN -> last pop -> DONE -> start -> RUN. Reset -> IDLE.
- Results are bit-exact against a reference model; order is preserved (FIFO).

Test Plan:
- Rounding: shift=8, relu=0, in_data=0x00012345 -> out_data=0x0123 at N+2, coords preserved.
- Negative rounding: shift=2, relu=0, in_data=-300 -> out_data=-75 (0xFFB5). Same input with relu=1 -> out_data=0.
- Saturation: shift=0, in_data=0x7FFFFFFF -> 0x7FFF and sat_flag=1. Then in_data=0x80000000 -> 0x8000. sat_flag stays 1 until start.
- Overflow: FIFO_DEPTH=8, out_ready=0, 9 consecutive in_valid (values 1..9, shift=0) -> overflow=1. Then out_ready=1 drains exactly 1..8 in order and out_valid drops.
- Done/counter: W=H=C=2, shift=0, 8 inputs, random out_ready -> done=1 the cycle after the 8th pop, busy=0. A 9th input still appears at the output and done stays 1.
- Reset mid-frame: assert arst_in with FIFO holding 3 entries, no clock edge needed -> out_valid=0, busy=0, overflow=0 immediately. After release and start, the next result appears at N+2.
